ps2_keymatrix: RTL and testbench



---
 rtl/ps2_keymatrix_pkg.sv | 39 +++
 rtl/ps2_keymatrix_keymap.sv | 82 ++++++++
 rtl/ps2_keymatrix.sv | 188 ++++++++++++++++++
 tb/tb_ps2_keymatrix.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_keymatrix_pkg.sv
// Shared types and constants for the PS/2 to Lynx key-matrix bridge.
package ps2_keymatrix_pkg;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

   typedef struct packed {
      logic       valid;
      logic [3:0] row;
      logic [2:0] col;
   } keypos_t;

   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam logic [7:0] PS2_BRK   = 8'hF0;
   localparam logic [7:0] PS2_PAUSE = 8'hE1;

   localparam int ROWS = 10;

   // Hotkey codes as {ext, scancode}
   localparam logic [8:0] KEY_CTRL_L = 9'h014;
   localparam logic [8:0] KEY_CTRL_R = 9'h114;
   localparam logic [8:0] KEY_ALT_L  = 9'h011;
   localparam logic [8:0] KEY_ALT_R  = 9'h111;
   localparam logic [8:0] KEY_DEL    = 9'h171;
   localparam logic [8:0] KEY_BKSP   = 9'h066;

   function automatic keypos_t mk(input logic [3:0] r, input logic [2:0] c);
      keypos_t p;
      p.valid = 1'b1;
      p.row   = r;
      p.col   = c;
      return p;
   endfunction

   // Keyboard status/ack bytes that never reach the decoder state.
   function automatic logic is_ignored(input logic [7:0] b);
      return b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
   endfunction

endpackage

// File: rtl/ps2_keymatrix_keymap.sv
// Scancode set 2 {ext, code} to Lynx matrix position lookup.
module ps2_keymap
   import ps2_keymatrix_pkg::*;
(
   input  logic [8:0] i_key,
   output keypos_t    o_pos
);

   always_comb begin
      o_pos = '0;
      case (i_key)
         // Row 0: modifiers and navigation
         9'h016: o_pos = mk(4'd0, 3'd0);
         9'h076: o_pos = mk(4'd0, 3'd1);
         9'h172: o_pos = mk(4'd0, 3'd2);
         9'h058: o_pos = mk(4'd0, 3'd3);
         9'h014: o_pos = mk(4'd0, 3'd4);
         9'h114: o_pos = mk(4'd0, 3'd4);
         9'h011: o_pos = mk(4'd0, 3'd5);
         9'h111: o_pos = mk(4'd0, 3'd5);
         9'h00D: o_pos = mk(4'd0, 3'd6);
         9'h012: o_pos = mk(4'd0, 3'd7);
         9'h059: o_pos = mk(4'd0, 3'd7);
         9'h026: o_pos = mk(4'd1, 3'd0);
         9'h025: o_pos = mk(4'd1, 3'd1);
         9'h024: o_pos = mk(4'd1, 3'd2);
         9'h022: o_pos = mk(4'd1, 3'd3);
         9'h023: o_pos = mk(4'd1, 3'd4);
         9'h021: o_pos = mk(4'd1, 3'd5);
         9'h01E: o_pos = mk(4'd2, 3'd0);
         9'h015: o_pos = mk(4'd2, 3'd1);
         9'h01D: o_pos = mk(4'd2, 3'd2);
         9'h01C: o_pos = mk(4'd2, 3'd3);
         9'h01B: o_pos = mk(4'd2, 3'd4);
         9'h01A: o_pos = mk(4'd2, 3'd5);
         9'h02E: o_pos = mk(4'd3, 3'd0);
         9'h02D: o_pos = mk(4'd3, 3'd1);
         9'h02C: o_pos = mk(4'd3, 3'd2);
         9'h02A: o_pos = mk(4'd3, 3'd3);
         9'h02B: o_pos = mk(4'd3, 3'd4);
         9'h034: o_pos = mk(4'd3, 3'd5);
         9'h036: o_pos = mk(4'd4, 3'd0);
         9'h035: o_pos = mk(4'd4, 3'd1);
         9'h033: o_pos = mk(4'd4, 3'd2);
         9'h032: o_pos = mk(4'd4, 3'd3);
         9'h031: o_pos = mk(4'd4, 3'd4);
         9'h03D: o_pos = mk(4'd5, 3'd0);
         9'h03E: o_pos = mk(4'd5, 3'd1);
         9'h03C: o_pos = mk(4'd5, 3'd2);
         9'h03B: o_pos = mk(4'd5, 3'd3);
         9'h03A: o_pos = mk(4'd5, 3'd4);
         9'h046: o_pos = mk(4'd6, 3'd0);
         9'h043: o_pos = mk(4'd6, 3'd1);
         9'h044: o_pos = mk(4'd6, 3'd2);
         9'h042: o_pos = mk(4'd6, 3'd3);
         9'h041: o_pos = mk(4'd6, 3'd4);
         9'h045: o_pos = mk(4'd7, 3'd0);
         9'h04D: o_pos = mk(4'd7, 3'd1);
         9'h04B: o_pos = mk(4'd7, 3'd2);
         9'h049: o_pos = mk(4'd7, 3'd3);
         9'h04C: o_pos = mk(4'd7, 3'd4);
         // Row 8: punctuation and cursor keys
         9'h04E: o_pos = mk(4'd8, 3'd0);
         9'h054: o_pos = mk(4'd8, 3'd1);
         9'h175: o_pos = mk(4'd8, 3'd2);
         9'h052: o_pos = mk(4'd8, 3'd3);
         9'h04A: o_pos = mk(4'd8, 3'd4);
         9'h174: o_pos = mk(4'd8, 3'd5);
         9'h16B: o_pos = mk(4'd8, 3'd6);
         9'h055: o_pos = mk(4'd9, 3'd0);
         9'h05B: o_pos = mk(4'd9, 3'd1);
         9'h171: o_pos = mk(4'd9, 3'd2);
         9'h029: o_pos = mk(4'd9, 3'd3);
         9'h066: o_pos = mk(4'd9, 3'd4);
         9'h05D: o_pos = mk(4'd9, 3'd5);
         9'h05A: o_pos = mk(4'd9, 3'd6);
         9'h15A: o_pos = mk(4'd9, 3'd6);
         default: o_pos = '0;
      endcase
   end

endmodule

// File: rtl/ps2_keymatrix.sv
// PS/2 keyboard receiver, scancode decoder and Lynx 10x8 key matrix with
// keyboard-driven reset/multiboot requests.
module ps2_keymatrix
   import ps2_keymatrix_pkg::*;
#(
   parameter int FILTER  = 8,
   parameter int TIMEOUT = 16000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ce,
   input  logic [1:0] ps2,
   input  logic [3:0] row,
   output logic [7:0] dout,   // 'do' is a reserved word, hence dout
   output logic       kreset,
   output logic       kboot
);

   localparam int FW = $clog2(FILTER + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [1:0]    r_clk_sync;
   logic [1:0]    r_dat_sync;
   logic          r_fclk;
   logic [FW-1:0] r_fcnt;
   logic          w_flip;
   logic          w_fall;
   logic          w_data;

   rx_state_t     r_state;
   logic [2:0]    r_bitcnt;
   logic [7:0]    r_shift;
   logic          r_par_ok;
   logic [TW-1:0] r_tcnt;
   logic          r_byte_vld;
   logic [7:0]    r_byte;

   logic          r_ext;
   logic          r_brk;
   logic [2:0]    r_skip;
   logic [7:0]    r_matrix [ROWS];
   logic          r_ctrl_l, r_ctrl_r, r_alt_l, r_alt_r, r_del, r_bksp;
   logic [8:0]    w_key;
   keypos_t       w_pos;
   logic          w_ctrl;
   logic          w_alt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_clk_sync <= 2'b11;
         r_dat_sync <= 2'b11;
      end else if (ce) begin
         r_clk_sync <= {r_clk_sync[0], ps2[0]};
         r_dat_sync <= {r_dat_sync[0], ps2[1]};
      end
   end

   // Glitch filter: the clock level flips only after FILTER differing samples in a row.
   assign w_flip = ce && (r_clk_sync[1] != r_fclk) && (r_fcnt == FW'(FILTER - 1));
   assign w_fall = w_flip && r_fclk;
   assign w_data = r_dat_sync[1];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_fclk <= 1'b1;
         r_fcnt <= '0;
      end else if (ce) begin
         if (r_clk_sync[1] == r_fclk) begin
            r_fcnt <= '0;
         end else if (w_flip) begin
            r_fclk <= ~r_fclk;
            r_fcnt <= '0;
         end else begin
            r_fcnt <= r_fcnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_bitcnt   <= '0;
         r_shift    <= '0;
         r_par_ok   <= 1'b0;
         r_tcnt     <= '0;
         r_byte_vld <= 1'b0;
         r_byte     <= '0;
      end else if (ce) begin
         r_byte_vld <= 1'b0;
         if (w_fall) begin
            r_tcnt <= '0;
            case (r_state)
               IDLE: begin
                  if (!w_data) begin
                     r_state  <= DATA;
                     r_bitcnt <= '0;
                  end
               end
               DATA: begin
                  r_shift  <= {w_data, r_shift[7:1]};
                  r_bitcnt <= r_bitcnt + 3'd1;
                  if (r_bitcnt == 3'd7) r_state <= PARITY;
               end
               PARITY: begin
                  r_par_ok <= ^{r_shift, w_data};
                  r_state  <= STOP;
               end
               STOP: begin
                  if (w_data && r_par_ok) begin
                     r_byte_vld <= 1'b1;
                     r_byte     <= r_shift;
                  end
                  r_state <= IDLE;
               end
               default: r_state <= IDLE;
            endcase
         end else if (r_state != IDLE) begin
            // A keyboard that stops mid-frame must not wedge the receiver.
            if (r_tcnt == TW'(TIMEOUT - 1)) begin
               r_state <= IDLE;
               r_tcnt  <= '0;
            end else begin
               r_tcnt <= r_tcnt + 1'b1;
            end
         end else begin
            r_tcnt <= '0;
         end
      end
   end

   assign w_key = {r_ext, r_byte};

   ps2_keymap u_keymap (
      .i_key (w_key),
      .o_pos (w_pos)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_ext    <= 1'b0;
         r_brk    <= 1'b0;
         r_skip   <= '0;
         r_ctrl_l <= 1'b0;
         r_ctrl_r <= 1'b0;
         r_alt_l  <= 1'b0;
         r_alt_r  <= 1'b0;
         r_del    <= 1'b0;
         r_bksp   <= 1'b0;
         for (int i = 0; i < ROWS; i++) r_matrix[i] <= 8'hFF;
      end else if (ce && r_byte_vld) begin
         if (r_skip != 3'd0) begin
            r_skip <= r_skip - 3'd1;
         end else if (r_byte == PS2_EXT) begin
            r_ext <= 1'b1;
         end else if (r_byte == PS2_BRK) begin
            r_brk <= 1'b1;
         end else if (r_byte == PS2_PAUSE) begin
            r_skip <= 3'd7;
         end else if (!is_ignored(r_byte)) begin
            // Make clears the bit (active-low), break sets it.
            if (w_pos.valid && (w_pos.row < 4'(ROWS)))
               r_matrix[w_pos.row][w_pos.col] <= r_brk;
            case (w_key)
               KEY_CTRL_L: r_ctrl_l <= ~r_brk;
               KEY_CTRL_R: r_ctrl_r <= ~r_brk;
               KEY_ALT_L:  r_alt_l  <= ~r_brk;
               KEY_ALT_R:  r_alt_r  <= ~r_brk;
               KEY_DEL:    r_del    <= ~r_brk;
               KEY_BKSP:   r_bksp   <= ~r_brk;
               default: ;
            endcase
            r_ext <= 1'b0;
            r_brk <= 1'b0;
         end
      end
   end

   always_comb begin
      dout = 8'hFF;
      if (row < 4'(ROWS)) dout = r_matrix[row];
   end

   assign w_ctrl = r_ctrl_l | r_ctrl_r;
   assign w_alt  = r_alt_l | r_alt_r;
   assign kreset = ~(w_ctrl & w_alt & r_del);
   assign kboot  = w_ctrl & w_alt & r_bksp;

endmodule

// File: tb/tb_ps2_keymatrix.sv
// Directed bench for ps2_keymatrix with a key-state model and per-cycle compare.
module tb_ps2_keymatrix;

   localparam int FILTER  = 8;
   localparam int TIMEOUT = 16000;
   localparam int HALF    = 20;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       ce    = 1'b1;
   logic [1:0] ps2   = 2'b11;
   logic [3:0] row   = 4'd0;
   logic [7:0] dout;
   logic       kreset;
   logic       kboot;

   ps2_keymatrix #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
      .clock  (clock),
      .reset  (reset),
      .ce     (ce),
      .ps2    (ps2),
      .row    (row),
      .dout   (dout),
      .kreset (kreset),
      .kboot  (kboot)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;
   bit ce_div   = 1'b0;

   initial begin
      forever begin
         @(posedge clock);
         #1;
         ce = ce_div ? ~ce : 1'b1;
      end
   end

   // Model: matrix contents, prefix state, and which keys are physically down.
   logic [7:0] m_mat [10];
   bit         m_ext;
   bit         m_brk;
   int         m_skip;
   bit         m_down [512];

   // Lynx position (row*8+col) of every key this bench sends; -1 if unmapped.
   function automatic int key_pos(input logic [8:0] k);
      case (k)
         9'h01C:         return 2*8 + 3;
         9'h029:         return 9*8 + 3;
         9'h012, 9'h059: return 0*8 + 7;
         9'h05A:         return 9*8 + 6;
         9'h175:         return 8*8 + 2;
         9'h014, 9'h114: return 0*8 + 4;
         9'h011, 9'h111: return 0*8 + 5;
         9'h171:         return 9*8 + 2;
         9'h066:         return 9*8 + 4;
         default:        return -1;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 10; i++) m_mat[i] = 8'hFF;
      for (int i = 0; i < 512; i++) m_down[i] = 1'b0;
      m_ext  = 1'b0;
      m_brk  = 1'b0;
      m_skip = 0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      logic [8:0] k;
      int         p;
      if (m_skip > 0) begin
         m_skip--;
      end else if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else if (b == 8'hE1) begin
         m_skip = 7;
      end else if (!(b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin
         k = {m_ext, b};
         p = key_pos(k);
         if (p >= 0) m_mat[p / 8][p % 8] = m_brk;
         m_down[k] = !m_brk;
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endtask

   function automatic logic [7:0] exp_dout(input logic [3:0] r);
      if (r < 4'd10) return m_mat[r];
      return 8'hFF;
   endfunction

   function automatic bit m_ctrl();
      return m_down[9'h014] || m_down[9'h114];
   endfunction

   function automatic bit m_alt();
      return m_down[9'h011] || m_down[9'h111];
   endfunction

   always @(negedge clock) begin
      if (chk_en) begin
         n_checks++;
         if (dout !== exp_dout(row)) begin
            n_errors++;
            $display("FAIL model_dout row=%0d actual=%h required=%h t=%0t", row, dout, exp_dout(row), $time);
         end
         n_checks++;
         if (kreset !== !(m_ctrl() && m_alt() && m_down[9'h171])) begin
            n_errors++;
            $display("FAIL model_kreset actual=%b required=%b t=%0t", kreset,
                     !(m_ctrl() && m_alt() && m_down[9'h171]), $time);
         end
         n_checks++;
         if (kboot !== (m_ctrl() && m_alt() && m_down[9'h066])) begin
            n_errors++;
            $display("FAIL model_kboot actual=%b required=%b t=%0t", kboot,
                     (m_ctrl() && m_alt() && m_down[9'h066]), $time);
         end
      end
   end

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic read_row(input string name, input logic [3:0] r, input logic [7:0] exp);
      row = r;
      @(negedge clock);
      check8(name, dout, exp);
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
         row = row + 4'd1;
      end
   endtask

   // Drives the first nfall bits of a frame: start, 8 data LSB first, odd parity, stop.
   task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nfall);
      logic [10:0] bits;
      int          hp;
      hp   = ce_div ? 2 * HALF : HALF;
      bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      chk_en = 1'b0;
      for (int i = 0; i < nfall; i++) begin
         ps2[1] = bits[i];
         idle(hp);
         ps2[0] = 1'b0;
         idle(hp);
         ps2[0] = 1'b1;
      end
      idle(hp);
      ps2[1] = 1'b1;
      idle(40);
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_bits(b, 1'b0, 11);
      model_byte(b);
      chk_en = 1'b1;
      idle(20);
   endtask

   initial begin
      model_reset();
      idle(5);
      reset = 1'b1;
      idle(5);
      chk_en = 1'b1;

      for (int r = 0; r < 16; r++) read_row("reset_row", 4'(r), 8'hFF);
      check8("reset_kreset", {7'd0, kreset}, 8'h01);
      check8("reset_kboot", {7'd0, kboot}, 8'h00);

      send_byte(8'h1C);
      read_row("make_A", 4'd2, 8'hF7);
      send_byte(8'hF0);
      send_byte(8'h1C);
      read_row("break_A", 4'd2, 8'hFF);

      send_byte(8'hE0);
      send_byte(8'h75);
      read_row("ext_up", 4'd8, 8'hFB);
      read_row("ext_up_row2", 4'd2, 8'hFF);
      send_byte(8'h75);
      read_row("plain_75", 4'd8, 8'hFB);
      send_byte(8'h1C);
      send_byte(8'h1C);
      read_row("repeat_make", 4'd2, 8'hF7);
      send_byte(8'hF0);
      send_byte(8'h1C);

      send_bits(8'h29, 1'b1, 11);
      chk_en = 1'b1;
      read_row("bad_parity", 4'd9, 8'hFF);
      send_bits(8'h29, 1'b0, 6);
      chk_en = 1'b1;
      idle(TIMEOUT + 10);
      send_byte(8'h29);
      read_row("after_timeout", 4'd9, 8'hF7);

      send_byte(8'h14);
      send_byte(8'h11);
      check8("kreset_two_keys", {7'd0, kreset}, 8'h01);
      send_byte(8'hE0);
      send_byte(8'h71);
      check8("kreset_combo", {7'd0, kreset}, 8'h00);
      read_row("ctrl_alt_row0", 4'd0, 8'hCF);
      send_byte(8'hF0);
      send_byte(8'h11);
      check8("kreset_release", {7'd0, kreset}, 8'h01);
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'h71);
      send_byte(8'hF0);
      send_byte(8'h14);
      send_byte(8'h14);
      send_byte(8'h11);
      send_byte(8'h66);
      check8("kboot_combo", {7'd0, kboot}, 8'h01);
      check8("kboot_kreset", {7'd0, kreset}, 8'h01);
      send_byte(8'hF0);
      send_byte(8'h66);
      check8("kboot_release", {7'd0, kboot}, 8'h00);
      send_byte(8'hF0);
      send_byte(8'h14);
      send_byte(8'hF0);
      send_byte(8'h11);

      ce_div = 1'b1;
      send_byte(8'h5A);
      read_row("slow_ce_return", 4'd9, 8'hB7);
      send_byte(8'hF0);
      send_byte(8'h5A);
      ce_div = 1'b0;
      idle(4);
      send_byte(8'hF0);
      send_byte(8'h29);
      send_byte(8'hFA);

      send_byte(8'hE1);
      send_byte(8'h14);
      send_byte(8'h77);
      send_byte(8'hE1);
      send_byte(8'hF0);
      send_byte(8'h14);
      send_byte(8'hF0);
      send_byte(8'h77);
      send_byte(8'h12);
      read_row("pause_shift", 4'd0, 8'h7F);

      send_bits(8'h1C, 1'b0, 4);
      reset = 1'b0;
      model_reset();
      idle(3);
      reset = 1'b1;
      idle(3);
      chk_en = 1'b1;
      for (int r = 0; r < 16; r++) read_row("midframe_reset", 4'(r), 8'hFF);
      send_byte(8'h1C);
      read_row("post_reset_frame", 4'd2, 8'hF7);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
